// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: MIPS multiply/divide unit holding the architectural HI/LO pair.
// Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO behind a start/busy/done handshake.
// Divide is restoring, one quotient bit per cycle; signed forms work on magnitudes
// and the sign is restored in the FIX state.
// Build option: define MULDIV_ITER_MULT_EN to run MULT/MULTU as 32 shift-add
// iterations through ITER/FIX instead of the single-cycle 32x32 multiplier.
module mips_muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUL_WB = 2'd1,
    S_ITER   = 2'd2,
    S_FIX    = 2'd3
  } state_t;

  // Conditional two's-complement negate, used for magnitudes and sign fix-up.
  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
    return neg ? (64'd0 - v) : v;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  // a_q: dividend/quotient shift register, multiplier/product low half,
  // or the raw dividend when dividing by zero
  logic [31:0] a_q, a_d;
  // b_q: divisor or multiplicand magnitude
  logic [31:0] b_q, b_d;
  // rem_q: 33-bit partial remainder; its low half is the product high half
  // while iterating a multiply
  logic [32:0] rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;     // quotient/product must be negated
  logic        rneg_q, rneg_d;   // remainder must be negated
  logic        dz_q, dz_d;       // divide by zero
`ifdef MULDIV_ITER_MULT_EN
  logic        mul_q, mul_d;     // current operation is a multiply
`endif

  logic        start_ok;
  logic        op_signed;
  logic        a_neg;
  logic        b_neg;
  logic        b_zero;
  logic [33:0] div_trial;
  logic [32:0] div_shift;

  assign start_ok  = start && (state_q == S_IDLE);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = op_signed && operand_a[31];
  assign b_neg     = op_signed && operand_b[31];
  assign b_zero    = (operand_b == 32'd0);

  // One restoring-division step: shift in next dividend bit and trial-subtract.
  assign div_shift = {rem_q[31:0], a_q[31]};
  assign div_trial = {rem_q, a_q[31]} - {2'b00, b_q};

`ifndef MULDIV_ITER_MULT_EN
  logic [63:0] mul_prod;
  // Single-cycle 32x32 magnitude multiply consumed in MUL_WB.
  assign mul_prod = {32'd0, a_q} * {32'd0, b_q};
`endif

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 33'd0;
      cnt_q   <= 6'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef MULDIV_ITER_MULT_EN
      mul_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
`ifdef MULDIV_ITER_MULT_EN
      mul_q   <= mul_d;
`endif
    end
  end

  // Next-state logic: sequence an accepted operation through the FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          case (op)
`ifdef MULDIV_ITER_MULT_EN
            OP_MULT, OP_MULTU: state_d = S_ITER;
`else
            OP_MULT, OP_MULTU: state_d = S_MUL_WB;
`endif
            OP_DIV, OP_DIVU:   state_d = b_zero ? S_FIX : S_ITER;
            default:           state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL_WB: state_d = S_IDLE;
      S_ITER: begin
        if (cnt_q == 6'd31) begin
          state_d = S_FIX;
        end else begin
          state_d = S_ITER;
        end
      end
      S_FIX:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic: operand capture, iterations, HI/LO write-back.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    busy_d = (state_d != S_IDLE);
    a_d    = a_q;
    b_d    = b_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
`ifdef MULDIV_ITER_MULT_EN
    mul_d  = mul_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          case (op)
            OP_MTHI: begin
              hi_d   = operand_a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = operand_a;
              done_d = 1'b1;
            end
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              // Divide by zero keeps the raw dividend so FIX can return it in HI.
              dz_d   = op[1] && b_zero;
              a_d    = (op[1] && b_zero) ? operand_a : cneg32(operand_a, a_neg);
              b_d    = cneg32(operand_b, b_neg);
              rem_d  = 33'd0;
              cnt_d  = 6'd0;
              neg_d  = a_neg ^ b_neg;
              rneg_d = a_neg;
`ifdef MULDIV_ITER_MULT_EN
              mul_d  = ~op[1];
`endif
            end
            default: begin
              done_d = 1'b0;
            end
          endcase
        end else begin
          done_d = 1'b0;
        end
      end
      S_MUL_WB: begin
`ifndef MULDIV_ITER_MULT_EN
        {hi_d, lo_d} = cneg64(mul_prod, neg_q);
        done_d       = 1'b1;
`endif
      end
      S_ITER: begin
        cnt_d = cnt_q + 6'd1;
`ifdef MULDIV_ITER_MULT_EN
        if (mul_q) begin
          // Shift-add: conditionally add multiplicand to the high half, shift right.
          logic [32:0] sum;
          sum   = {1'b0, rem_q[31:0]} + (a_q[0] ? {1'b0, b_q} : 33'd0);
          rem_d = {1'b0, sum[32:1]};
          a_d   = {sum[0], a_q[31:1]};
        end else begin
          rem_d = div_trial[33] ? div_shift : div_trial[32:0];
          a_d   = {a_q[30:0], ~div_trial[33]};
        end
`else
        rem_d = div_trial[33] ? div_shift : div_trial[32:0];
        a_d   = {a_q[30:0], ~div_trial[33]};
`endif
      end
      S_FIX: begin
        done_d = 1'b1;
        if (dz_q) begin
          hi_d = a_q;
          lo_d = 32'hFFFF_FFFF;
`ifdef MULDIV_ITER_MULT_EN
        end else if (mul_q) begin
          {hi_d, lo_d} = cneg64({rem_q[31:0], a_q}, neg_q);
`endif
        end else begin
          lo_d = cneg32(a_q, neg_q);
          hi_d = cneg32(rem_q[31:0], rneg_q);
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed steps, expected HI/LO and
// latency pushed to a scoreboard queue at issue, popped when done is seen.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] ehi;
    logic [31:0] elo;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

`ifdef MULDIV_ITER_MULT_EN
  localparam int MUL_LAT = 34;
`else
  localparam int MUL_LAT = 2;
`endif

  mips_muldiv_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait for done (bounded), then check against the scoreboard.
  // inject > 0 drives an MTLO 0xAAAA start after that many edges, which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat, input logic ebusy, input int inject);
    exp_t        e;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          edges;
    logic        held;
    sb.push_back('{ehi, elo, elat});
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    old_hi = hi; old_lo = lo;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    held  = 1'b1;
    check({tag, "_busy_after_start"}, {63'd0, busy}, {63'd0, ebusy});
    while (done !== 1'b1 && edges < 60) begin
      if (busy === 1'b1 && (hi !== old_hi || lo !== old_lo)) held = 1'b0;
      if (edges == inject) begin
        start = 1'b1; op = 3'b101; operand_a = 32'h0000_AAAA;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check({tag, "_done"},    {63'd0, done}, 64'd1);
    check({tag, "_hi"},      {32'd0, hi}, {32'd0, e.ehi});
    check({tag, "_lo"},      {32'd0, lo}, {32'd0, e.elo});
    check({tag, "_latency"}, 64'(edges), 64'(e.lat));
    check({tag, "_held"},    {63'd0, held}, 64'd1);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    exp_t e;
    int   done_seen;
    logic [31:0] keep_hi;
    logic [31:0] keep_lo;

    reset = 1'b1; start = 1'b0; op = 3'b000; operand_a = 32'd0; operand_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi",   {32'd0, hi}, 64'd0);
    check("reset_lo",   {32'd0, lo}, 64'd0);
    check("reset_ctrl", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mthi", 3'b100, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'h0000_0000, 1, 1'b0, 0);
    run_op("mtlo", 3'b101, 32'h9ABC_DEF0, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1, 1'b0, 0);

    // Illegal op: no done, no busy, HI/LO untouched.
    keep_hi = hi; keep_lo = lo;
    @(negedge clk);
    start = 1'b1; op = 3'b110; operand_a = 32'hDEAD_BEEF; operand_b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("illegal_no_activity", 64'(done_seen), 64'd0);
    check("illegal_hilo", {hi, lo}, {keep_hi, keep_lo});

    run_op("mult",      3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT, 1'b1, 0);
    run_op("multu",     3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, MUL_LAT, 1'b1, 0);
    run_op("mult_neg",  3'b000, 32'h0000_0007, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, MUL_LAT, 1'b1, 0);
    run_op("div_m7_2",  3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1'b1, 0);
    run_op("divu_100_7",3'b011, 32'd100,       32'd7,         32'd2,         32'd14,        34, 1'b1, 0);
    run_op("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34, 1'b1, 0);
    run_op("div_7_m2",  3'b010, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34, 1'b1, 0);
    run_op("divu_big",  3'b011, 32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999, 34, 1'b1, 0);
    run_op("divu_by0",  3'b011, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 2,  1'b1, 0);
    run_op("div_by0_s", 3'b010, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 2,  1'b1, 0);
    run_op("divu_inj",  3'b011, 32'd1000,      32'd33,        32'd10,        32'd30,        34, 1'b1, 5);

    // Reset at edge 10 of a divide: everything returns to reset values, no done.
    sb.push_back('{32'd0, 32'd0, 0});
    @(negedge clk);
    start = 1'b1; op = 3'b010; operand_a = 32'd1000; operand_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    done_seen = 0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    e = sb.pop_front();
    check("rst_mid_hi",   {32'd0, hi}, {32'd0, e.ehi});
    check("rst_mid_lo",   {32'd0, lo}, {32'd0, e.elo});
    check("rst_mid_ctrl", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("rst_mid_no_done", 64'(done_seen), 64'd0);

    run_op("divu_9_3", 3'b011, 32'd9, 32'd3, 32'd0, 32'd3, 34, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Multiply/divide unit with HI/LO registers for the multicycle MIPS core, directly downstream of the register file: it consumes `register_a_data` (rs) and `register_b_data` (rt) as operands. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO pair read by MFHI/MFLO. A start/busy/done handshake lets the control FSM stall until results are valid.

## Interface

Parameters:
- none (datapath fixed at 32 bits)

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: begin operation `op`; sampled on rising edge of `clk`.
- `op` in 3: operation code.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are ignored.
- `operand_a` in 32: rs value from the register file.
- `operand_b` in 32: rt value from the register file.
- `hi` out 32: architectural HI register.
- `lo` out 32: architectural LO register.
- `busy` out 1: operation in progress; new `start` is ignored.
- `done` out 1: one-cycle pulse; `hi`/`lo` were updated at the preceding edge.

## Operation

- States: IDLE, MUL_WB, ITER, FIX.
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state=IDLE.
- Reset mid-operation aborts the operation and applies the reset values; no `done` pulse is produced.
- `start` in IDLE with an illegal op (110/111): no state change, no `done`.
- `start` while `busy`=1: ignored, with no effect on the running operation.
- MTHI / MTLO:
  - `hi` (resp. `lo`) ← `operand_a` at the start edge.
  - `done`=1 the following cycle.
  - `busy` is never asserted.
- MULT / MULTU:
  - Operands are latched at the start edge.
  - Result is the 64-bit product: {hi,lo} = a×b.
  - MULT is two's-complement signed; MULTU is unsigned.
- DIV / DIVU:
  - Operands are latched at the start edge.
  - Restoring division, one quotient bit per cycle in ITER (32 cycles); a 6-bit counter counts 0..31.
  - FIX applies sign correction: quotient negative iff operand signs differ (signed only); remainder takes the sign of the dividend.
  - Quotient truncates toward zero. `lo` = quotient, `hi` = remainder.
  - Signed 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0 (natural wrap, no trap).
- Divide by zero (`operand_b`=0, DIV or DIVU):
  - Skip ITER; go IDLE→FIX directly.
  - Result `hi`=`operand_a`, `lo`=0xFFFFFFFF.
- `hi`/`lo` hold their previous values for the whole of `busy`; both update together, in one edge.
- Signed arithmetic uses magnitudes internally: negate when the sign bit is set, then negate the result in FIX. Intermediate widths: 33-bit partial remainder, 64-bit product accumulator.

## Timing

- Edge 0 denotes the edge where `start` is sampled.
- `busy` rises after edge 0 for MULT/MULTU/DIV/DIVU. It falls at the same edge that writes `hi`/`lo` and raises `done`.
- Fast multiply: edge 0 → MUL_WB; edge 1 writes `hi`/`lo`; `done` high in cycle 1–2. Latency 2 edges.
- Divide: edge 0 → ITER; edges 1..32 perform iterations; edge 32 → FIX; edge 33 writes the result; `done` high after edge 33.
- Divide by zero: edge 0 → FIX; edge 1 writes the result.
- A new `start` is accepted in the same cycle `done` is high, since `busy` is already 0.

## Configuration

- `MULDIV_ITER_MULT_EN` defined:
  - MULT/MULTU use the ITER/FIX path as 32 shift-add iterations plus sign fix.
  - Latency matches divide: result written at edge 33.
  - No 32×32 array multiplier is instantiated.
- `MULDIV_ITER_MULT_EN` undefined:
  - Single-cycle combinational 32×32 multiply through MUL_WB; latency 2 edges.
- Divide, MTHI/MTLO and the handshake are identical in both builds.

## Test plan

- Reset, then MTHI 0x12345678 and MTLO 0x9ABCDEF0 → `hi`=0x12345678, `lo`=0x9ABCDEF0, one `done` pulse each, `busy` stays 0.
- MULT 0xFFFFFFFE × 0x00000003 → {hi,lo}=0xFFFFFFFF_FFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA. Latency 2 edges, or 34 edges with `MULDIV_ITER_MULT_EN`.
- DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 → lo=14, hi=2. `done` exactly 34 edges after start; `hi`/`lo` unchanged while `busy`.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 5 / 0 → hi=5, lo=0xFFFFFFFF, `done` after 2 edges.
- Second `start` (MTLO 0xAAAA) mid-divide → ignored; only the divide result appears, with a single `done`.
- Assert `reset` at edge 10 of a divide → hi=lo=0, `busy`=0, no `done`. A new DIVU 9/3 then completes normally: lo=3, hi=0.
